fb_write_arbiter: RTL and testbench
===================================

FB_WRITE_ARBITER -- requirements
Module: fb_write_arbiter

Interface
REQ-001 Parameter X_MAX, default 8'd255, is the last column swept by a clear.
REQ-002 Parameter Y_MAX, default 8'd255, is the last row swept by a clear.
REQ-003 Parameter CLR_RGB, default 9'h000, is the {r,g,b} colour written by a clear.
REQ-004 CLK  in  1  sole clock; all state updates on rising edge.
REQ-005 RST  in  1  reset, synchronous, active-high.
REQ-006 req0_valid / req0_ready  in/out  1/1  draw-engine request handshake.
REQ-007 req0_x, req0_y  in  8 each  draw-engine pixel coordinate.
REQ-008 req0_r, req0_g, req0_b  in  3 each  draw-engine colour.
REQ-009 req1_valid / req1_ready, req1_x, req1_y, req1_r, req1_g, req1_b  in/out  same widths as req0  manual XY-input request.
REQ-010 clr_start  in  1  one-cycle clear-screen request.
REQ-011 clr_busy  out  1  clear sweep in progress.
REQ-012 clr_done  out  1  one-cycle pulse after the last clear pixel is accepted.
REQ-013 wr_ok  in  1  frame-buffer write port accepts the presented pixel this cycle.
REQ-014 write_we  out  1  pixel valid toward the VGA controller write port.
REQ-015 write_x, write_y  out  8 each; write_r, write_g, write_b  out  3 each  registered pixel toward the VGA controller.

Function
REQ-016 Output stage is one register; write_we=1 holds write_x/y/r/g/b stable until a rising edge with wr_ok=1, which retires the pixel.
REQ-017 Output stage is "free" when write_we=0 or (write_we=1 and wr_ok=1); a new pixel can be loaded in the same edge that retires the previous one.
REQ-018 FSM states IDLE, DRAIN, CLEAR; IDLE is the reset state.
REQ-019 In IDLE, reqN_ready=1 only when the output stage is free and the round-robin grant selects N; ready is combinational from valid, grant, state and wr_ok.
REQ-020 Transfer on reqN_valid & reqN_ready; the pixel appears on write_* with write_we=1 the next cycle (latency 1).
REQ-021 Round-robin: a single valid requester is granted; when both are valid the requester not served last is granted; last-served pointer resets to 1, so req0 wins the first tie.
REQ-022 Last-served pointer updates only on an actual transfer.
REQ-023 clr_start in IDLE: go to DRAIN if write_we=1 and wr_ok=0, otherwise go directly to CLEAR; no requester transfer occurs in that cycle.
REQ-024 DRAIN: both ready=0; go to CLEAR on the edge where the pending pixel retires.
REQ-025 CLEAR: clr_busy=1 and both ready=0; issue pixels (x,y,CLR_RGB) with y from 0 to Y_MAX as the outer loop and x from 0 to X_MAX as the inner loop; advance one pixel per retire.
REQ-026 A clear writes exactly (X_MAX+1)*(Y_MAX+1) pixels; the x counter wraps to 0 and y increments when x=X_MAX retires.
REQ-027 When pixel (X_MAX,Y_MAX) retires: clr_done=1 for one cycle, write_we=0, and the state returns to IDLE.
REQ-028 clr_start while in DRAIN or CLEAR is ignored and does not restart the sweep.
REQ-029 clr_busy=1 in DRAIN and CLEAR.
REQ-030 Requester valid deasserting without a transfer is legal; the arbiter keeps no memory of it.

Reset
REQ-031 While RST=1 at a clock edge: state=IDLE, write_we=0, write_x/y/r/g/b=0, clr_busy=0, clr_done=0, last-served=1, clear counters=0.
REQ-032 RST asserted mid-clear or mid-write abandons the operation; no pixel is presented after reset until a new transfer.
REQ-033 reqN_ready=0 while RST=1.

Structure
REQ-034 Shared package fbw_pkg holds the state enum, COORD_W=8, COLOR_W=3, and the pixel struct {x,y,r,g,b}.
REQ-035 Two-way round-robin grant logic is a sub-module rr_arb2 (inputs req[1:0], update, last; output grant), reused by the team's other shared ports.

Verification
REQ-036 Only req0 valid with (10,20,7,0,3), wr_ok=1 -> req0_ready=1; next cycle write_we=1 with write_x=10, write_y=20, rgb=7/0/3.
REQ-037 Both valid every cycle, wr_ok=1 -> grants alternate 0,1,0,1 starting with req0; one transfer per cycle.
REQ-038 write_we=1 with wr_ok held 0 for 5 cycles -> write_* stable and both ready=0 for 5 cycles; retire on the 6th edge.
REQ-039 X_MAX=3, Y_MAX=1, wr_ok=1, pulse clr_start -> 8 pixels (0,0)..(3,0),(0,1)..(3,1) with CLR_RGB; clr_done pulses once; clr_busy=1 for 8 cycles.
REQ-040 clr_start while write_we=1 and wr_ok=0 -> DRAIN until the pending pixel retires, then the clear sweep starts at (0,0); second clr_start mid-sweep has no effect.
REQ-041 RST pulse at clear pixel 3 -> next cycle write_we=0, clr_busy=0; after release, req1 is serviced normally.

Source files
------------

// File: rtl/fb_write_arbiter_pkg.sv
// Shared types for the frame-buffer write arbiter: FSM states, field widths
// and the pixel record that travels through the output register.
package fbw_pkg;

    localparam int COORD_W = 8;
    localparam int COLOR_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fbw_state_e;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] r;
        logic [COLOR_W-1:0] g;
        logic [COLOR_W-1:0] b;
    } pixel_t;

    // Build a pixel from a coordinate pair and a packed {r,g,b} colour.
    function automatic pixel_t make_pixel(
        input logic [COORD_W-1:0]   x,
        input logic [COORD_W-1:0]   y,
        input logic [3*COLOR_W-1:0] rgb
    );
        pixel_t p;
        p.x = x;
        p.y = y;
        p.r = rgb[3*COLOR_W-1:2*COLOR_W];
        p.g = rgb[2*COLOR_W-1:COLOR_W];
        p.b = rgb[COLOR_W-1:0];
        return p;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_arb2.sv
// Two-way round-robin grant. Purely combinational: the caller owns the
// last-served flop and feeds it back through 'last'; 'last_nxt' is the value
// that flop should take, moving only when 'update' reports a real transfer.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       update,
    input  logic       last,
    output logic [1:0] grant,
    output logic       last_nxt
);

    // Lone requester wins; on a tie the one not served last wins
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Pointer follows the granted requester only on an actual transfer
    always_comb begin
        last_nxt = last;
        if (update && grant[1]) begin
            last_nxt = 1'b1;
        end else if (update && grant[0]) begin
            last_nxt = 1'b0;
        end else begin
            last_nxt = last;
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Frame-buffer write arbiter: merges the draw engine (req0) and the manual
// XY input (req1) into one registered pixel port, and can take the port over
// to sweep a solid clear colour across the whole screen.
module fb_write_arbiter
    import fbw_pkg::*;
#(
    parameter logic [COORD_W-1:0]   X_MAX   = 8'd255,
    parameter logic [COORD_W-1:0]   Y_MAX   = 8'd255,
    parameter logic [3*COLOR_W-1:0] CLR_RGB = 9'h000
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [COORD_W-1:0] req0_x,
    input  logic [COORD_W-1:0] req0_y,
    input  logic [COLOR_W-1:0] req0_r,
    input  logic [COLOR_W-1:0] req0_g,
    input  logic [COLOR_W-1:0] req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [COORD_W-1:0] req1_x,
    input  logic [COORD_W-1:0] req1_y,
    input  logic [COLOR_W-1:0] req1_r,
    input  logic [COLOR_W-1:0] req1_g,
    input  logic [COLOR_W-1:0] req1_b,
    input  logic               clr_start,
    output logic               clr_busy,
    output logic               clr_done,
    input  logic               wr_ok,
    output logic               write_we,
    output logic [COORD_W-1:0] write_x,
    output logic [COORD_W-1:0] write_y,
    output logic [COLOR_W-1:0] write_r,
    output logic [COLOR_W-1:0] write_g,
    output logic [COLOR_W-1:0] write_b
);

    fbw_state_e         state_q,    state_d;
    pixel_t             wr_pix_q,   wr_pix_d;
    logic               write_we_q, write_we_d;
    logic               clr_busy_q, clr_busy_d;
    logic               clr_done_q, clr_done_d;
    logic               last_q,     last_d;
    logic [COORD_W-1:0] clr_x_q,    clr_x_d;
    logic [COORD_W-1:0] clr_y_q,    clr_y_d;

    logic               retire_s;
    logic               out_free_s;
    logic               xfer0_s;
    logic               xfer1_s;
    logic [1:0]         grant_s;
    logic               last_nxt_s;
    pixel_t             req0_pix_s;
    pixel_t             req1_pix_s;

    assign retire_s   = write_we_q & wr_ok;
    assign out_free_s = ~write_we_q | wr_ok;
    assign xfer0_s    = req0_valid & req0_ready;
    assign xfer1_s    = req1_valid & req1_ready;
    assign req0_pix_s = make_pixel(req0_x, req0_y, {req0_r, req0_g, req0_b});
    assign req1_pix_s = make_pixel(req1_x, req1_y, {req1_r, req1_g, req1_b});

    rr_arb2 u_rr_arb2 (
        .req      ({req1_valid, req0_valid}),
        .update   (xfer0_s | xfer1_s),
        .last     (last_q),
        .grant    (grant_s),
        .last_nxt (last_nxt_s)
    );

    // Requesters are accepted only in IDLE with room in the output register;
    // a clear-start cycle and reset block acceptance so no pixel is lost
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if (!RST && (state_q == IDLE) && !clr_start && out_free_s) begin
            req0_ready = grant_s[0];
            req1_ready = grant_s[1];
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    // Next state, next output pixel and clear-sweep counters
    always_comb begin
        state_d    = state_q;
        wr_pix_d   = wr_pix_q;
        clr_x_d    = clr_x_q;
        clr_y_d    = clr_y_q;
        clr_done_d = 1'b0;
        last_d     = last_nxt_s;
        if (retire_s) begin
            write_we_d = 1'b0;
        end else begin
            write_we_d = write_we_q;
        end

        case (state_q)
            IDLE: begin
                if (clr_start) begin
                    if (write_we_q && !wr_ok) begin
                        state_d = DRAIN;
                    end else begin
                        state_d    = CLEAR;
                        clr_x_d    = {COORD_W{1'b0}};
                        clr_y_d    = {COORD_W{1'b0}};
                        wr_pix_d   = make_pixel({COORD_W{1'b0}}, {COORD_W{1'b0}}, CLR_RGB);
                        write_we_d = 1'b1;
                    end
                end else if (xfer0_s) begin
                    wr_pix_d   = req0_pix_s;
                    write_we_d = 1'b1;
                end else if (xfer1_s) begin
                    wr_pix_d   = req1_pix_s;
                    write_we_d = 1'b1;
                end else begin
                    wr_pix_d = wr_pix_q;
                end
            end
            DRAIN: begin
                // Sweep starts at the same edge that frees the port
                if (retire_s) begin
                    state_d    = CLEAR;
                    clr_x_d    = {COORD_W{1'b0}};
                    clr_y_d    = {COORD_W{1'b0}};
                    wr_pix_d   = make_pixel({COORD_W{1'b0}}, {COORD_W{1'b0}}, CLR_RGB);
                    write_we_d = 1'b1;
                end else begin
                    state_d = DRAIN;
                end
            end
            CLEAR: begin
                if (retire_s) begin
                    if (clr_x_q == X_MAX) begin
                        if (clr_y_q == Y_MAX) begin
                            state_d    = IDLE;
                            clr_done_d = 1'b1;
                            clr_x_d    = {COORD_W{1'b0}};
                            clr_y_d    = {COORD_W{1'b0}};
                        end else begin
                            clr_x_d    = {COORD_W{1'b0}};
                            clr_y_d    = clr_y_q + 8'd1;
                            wr_pix_d   = make_pixel(clr_x_d, clr_y_d, CLR_RGB);
                            write_we_d = 1'b1;
                        end
                    end else begin
                        clr_x_d    = clr_x_q + 8'd1;
                        wr_pix_d   = make_pixel(clr_x_d, clr_y_q, CLR_RGB);
                        write_we_d = 1'b1;
                    end
                end else begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d    = IDLE;
                write_we_d = 1'b0;
            end
        endcase

        clr_busy_d = (state_d != IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            wr_pix_q   <= '0;
            write_we_q <= 1'b0;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
            last_q     <= 1'b1;
            clr_x_q    <= {COORD_W{1'b0}};
            clr_y_q    <= {COORD_W{1'b0}};
        end else begin
            state_q    <= state_d;
            wr_pix_q   <= wr_pix_d;
            write_we_q <= write_we_d;
            clr_busy_q <= clr_busy_d;
            clr_done_q <= clr_done_d;
            last_q     <= last_d;
            clr_x_q    <= clr_x_d;
            clr_y_q    <= clr_y_d;
        end
    end

    assign write_we = write_we_q;
    assign write_x  = wr_pix_q.x;
    assign write_y  = wr_pix_q.y;
    assign write_r  = wr_pix_q.r;
    assign write_g  = wr_pix_q.g;
    assign write_b  = wr_pix_q.b;
    assign clr_busy = clr_busy_q;
    assign clr_done = clr_done_q;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: a vector table for arbitration
// and stall behaviour, directed clear/drain/reset sequences, then random
// traffic compared against a transaction-level reference model.
module tb_fb_write_arbiter;

    localparam logic [7:0] XM   = 8'd3;
    localparam logic [7:0] YM   = 8'd1;
    localparam logic [8:0] CRGB = 9'h156;
    localparam int         NPIX = (int'(XM) + 1) * (int'(YM) + 1);

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       req0_valid = 1'b0, req1_valid = 1'b0;
    logic       req0_ready, req1_ready;
    logic [7:0] req0_x = 8'd0, req0_y = 8'd0, req1_x = 8'd0, req1_y = 8'd0;
    logic [2:0] req0_r = 3'd0, req0_g = 3'd0, req0_b = 3'd0;
    logic [2:0] req1_r = 3'd0, req1_g = 3'd0, req1_b = 3'd0;
    logic       clr_start = 1'b0, wr_ok = 1'b0;
    logic       clr_busy, clr_done, write_we;
    logic [7:0] write_x, write_y;
    logic [2:0] write_r, write_g, write_b;

    fb_write_arbiter #(.X_MAX(XM), .Y_MAX(YM), .CLR_RGB(CRGB)) dut (
        .CLK(CLK), .RST(RST),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_x(req0_x), .req0_y(req0_y), .req0_r(req0_r), .req0_g(req0_g), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_x(req1_x), .req1_y(req1_y), .req1_r(req1_r), .req1_g(req1_g), .req1_b(req1_b),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .wr_ok(wr_ok), .write_we(write_we),
        .write_x(write_x), .write_y(write_y),
        .write_r(write_r), .write_g(write_g), .write_b(write_b)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // Reference model: mode 0 idle, 1 waiting for the port, 2 sweeping
    int       m_mode = 0;
    bit       m_we   = 1'b0;
    bit [7:0] m_x    = 8'd0, m_y = 8'd0;
    bit [8:0] m_rgb  = 9'd0;
    int       m_last = 1;
    int       m_k    = 0;
    bit       m_busy = 1'b0, m_done = 1'b0;

    // Observation counters for the directed sequences
    int       busy_cnt = 0, done_cnt = 0, npix = 0;
    bit [7:0] cap_x[16];
    bit [7:0] cap_y[16];

    typedef struct {
        bit       rst, v0, v1, ok;
        bit [7:0] x0, y0; bit [8:0] c0;
        bit [7:0] x1, y1; bit [8:0] c1;
        bit       er0, er1, ewe;
        bit [7:0] ex, ey; bit [8:0] ec;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic void model_ready(output bit r0, output bit r1);
        int w;
        r0 = 1'b0;
        r1 = 1'b0;
        if (RST || m_mode != 0 || clr_start || (m_we && !wr_ok)) return;
        if (req0_valid && req1_valid) w = (m_last == 0) ? 1 : 0;
        else if (req0_valid)          w = 0;
        else if (req1_valid)          w = 1;
        else return;
        if (w == 0) r0 = 1'b1;
        else        r1 = 1'b1;
    endfunction

    function automatic void load_clear();
        m_we  = 1'b1;
        m_x   = 8'(m_k % (int'(XM) + 1));
        m_y   = 8'(m_k / (int'(XM) + 1));
        m_rgb = CRGB;
    endfunction

    function automatic void model_step();
        bit r0, r1, retire;
        model_ready(r0, r1);
        retire = m_we && wr_ok;
        m_done = 1'b0;
        if (RST) begin
            m_mode = 0; m_we = 1'b0; m_x = 8'd0; m_y = 8'd0; m_rgb = 9'd0;
            m_last = 1; m_k = 0;
        end else begin
            case (m_mode)
                0: begin
                    if (clr_start) begin
                        if (m_we && !wr_ok) m_mode = 1;
                        else begin m_mode = 2; m_k = 0; load_clear(); end
                    end else begin
                        if (retire) m_we = 1'b0;
                        if (r0) begin
                            m_we = 1'b1; m_x = req0_x; m_y = req0_y;
                            m_rgb = {req0_r, req0_g, req0_b}; m_last = 0;
                        end else if (r1) begin
                            m_we = 1'b1; m_x = req1_x; m_y = req1_y;
                            m_rgb = {req1_r, req1_g, req1_b}; m_last = 1;
                        end
                    end
                end
                1: if (wr_ok) begin m_mode = 2; m_k = 0; load_clear(); end
                default: if (retire) begin
                    if (m_k == NPIX - 1) begin m_we = 1'b0; m_done = 1'b1; m_mode = 0; end
                    else begin m_k++; load_clear(); end
                end
            endcase
        end
        m_busy = (m_mode != 0);
    endfunction

    // One clock: drive inputs after the falling edge, check ready, clock, check outputs
    task automatic tick(input bit rst, input bit clr, input bit ok,
                        input bit v0, input bit [7:0] x0, input bit [7:0] y0, input bit [8:0] c0,
                        input bit v1, input bit [7:0] x1, input bit [7:0] y1, input bit [8:0] c1,
                        output bit rd0, output bit rd1);
        bit e0, e1;
        @(negedge CLK);
        RST = rst; clr_start = clr; wr_ok = ok;
        req0_valid = v0; req0_x = x0; req0_y = y0; {req0_r, req0_g, req0_b} = c0;
        req1_valid = v1; req1_x = x1; req1_y = y1; {req1_r, req1_g, req1_b} = c1;
        #1;
        rd0 = req0_ready;
        rd1 = req1_ready;
        model_ready(e0, e1);
        chk("req0_ready", rd0, e0);
        chk("req1_ready", rd1, e1);
        model_step();
        @(posedge CLK);
        #1;
        chk("write_we", write_we, m_we);
        if (m_we) begin
            chk("write_x", write_x, m_x);
            chk("write_y", write_y, m_y);
            chk("write_rgb", {write_r, write_g, write_b}, m_rgb);
        end
        chk("clr_busy", clr_busy, m_busy);
        chk("clr_done", clr_done, m_done);
        if (clr_busy) busy_cnt++;
        if (clr_done) done_cnt++;
        if (write_we && clr_busy && npix < 16) begin
            cap_x[npix] = write_x;
            cap_y[npix] = write_y;
            npix++;
        end
    endtask

    task automatic clr_counts();
        busy_cnt = 0; done_cnt = 0; npix = 0;
    endtask

    task automatic idle_tick(input bit clr, input bit ok, output bit rd0, output bit rd1);
        tick(1'b0, clr, ok, 1'b0, 8'd0, 8'd0, 9'd0, 1'b0, 8'd0, 8'd0, 9'd0, rd0, rd1);
    endtask

    initial begin
        bit rd0, rd1;

        //          rst   v0    v1    ok    x0     y0     c0      x1    y1    c1      er0   er1   ewe   ex     ey     ec
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  9'h000, 8'd0, 8'd0, 9'h000, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  9'h000};
        tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd1,  8'd2,  9'h049, 8'd3, 8'd4, 9'h092, 1'b1, 1'b0, 1'b1, 8'd1,  8'd2,  9'h049};
        tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd1,  8'd2,  9'h049, 8'd3, 8'd4, 9'h092, 1'b0, 1'b1, 1'b1, 8'd3,  8'd4,  9'h092};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd1,  8'd2,  9'h049, 8'd3, 8'd4, 9'h092, 1'b1, 1'b0, 1'b1, 8'd1,  8'd2,  9'h049};
        tbl[4]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'd1,  8'd2,  9'h049, 8'd3, 8'd4, 9'h092, 1'b0, 1'b1, 1'b1, 8'd3,  8'd4,  9'h092};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 8'd10, 8'd20, 9'h1C3, 8'd0, 8'd0, 9'h000, 1'b1, 1'b0, 1'b1, 8'd10, 8'd20, 9'h1C3};
        for (int i = 6; i <= 10; i++)
            tbl[i] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 9'h000, 8'd3, 8'd4, 9'h092, 1'b0, 1'b0, 1'b1, 8'd10, 8'd20, 9'h1C3};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b1, 8'd0,  8'd0,  9'h000, 8'd3, 8'd4, 9'h092, 1'b0, 1'b1, 1'b1, 8'd3,  8'd4,  9'h092};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd0,  8'd0,  9'h000, 8'd0, 8'd0, 9'h000, 1'b0, 1'b0, 1'b0, 8'd0,  8'd0,  9'h000};

        // Vector table: reset, alternating tie grants, single request, 5-cycle stall
        for (int i = 0; i < 13; i++) begin
            tick(tbl[i].rst, 1'b0, tbl[i].ok,
                 tbl[i].v0, tbl[i].x0, tbl[i].y0, tbl[i].c0,
                 tbl[i].v1, tbl[i].x1, tbl[i].y1, tbl[i].c1, rd0, rd1);
            chk($sformatf("tbl%0d_rdy0", i), rd0, tbl[i].er0);
            chk($sformatf("tbl%0d_rdy1", i), rd1, tbl[i].er1);
            chk($sformatf("tbl%0d_we", i), write_we, tbl[i].ewe);
            if (tbl[i].ewe || tbl[i].rst) begin
                chk($sformatf("tbl%0d_x", i), write_x, tbl[i].ex);
                chk($sformatf("tbl%0d_y", i), write_y, tbl[i].ey);
                chk($sformatf("tbl%0d_rgb", i), {write_r, write_g, write_b}, tbl[i].ec);
            end
        end

        // Full clear sweep from idle with the port always accepting
        clr_counts();
        idle_tick(1'b1, 1'b1, rd0, rd1);
        for (int i = 0; i < 10; i++) idle_tick(1'b0, 1'b1, rd0, rd1);
        chk("clr_busy_cycles", busy_cnt, NPIX);
        chk("clr_done_pulses", done_cnt, 1);
        chk("clr_pix_count", npix, NPIX);
        for (int i = 0; i < NPIX && i < 16; i++) begin
            chk($sformatf("clr_pix%0d_x", i), cap_x[i], i % (int'(XM) + 1));
            chk($sformatf("clr_pix%0d_y", i), cap_y[i], i / (int'(XM) + 1));
        end

        // Clear requested while a pixel is stalled: drain first, restart request ignored
        tick(1'b0, 1'b0, 1'b1, 1'b1, 8'd5, 8'd6, 9'h0AA, 1'b0, 8'd0, 8'd0, 9'd0, rd0, rd1);
        idle_tick(1'b1, 1'b0, rd0, rd1);
        chk("drain_busy", clr_busy, 1'b1);
        chk("drain_hold_x", write_x, 8'd5);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd7, 8'd7, 9'h001, 1'b1, 8'd8, 8'd8, 9'h002, rd0, rd1);
        chk("drain_rdy0", rd0, 1'b0);
        chk("drain_rdy1", rd1, 1'b0);
        clr_counts();
        idle_tick(1'b0, 1'b1, rd0, rd1);
        chk("drain_first_x", write_x, 8'd0);
        chk("drain_first_y", write_y, 8'd0);
        idle_tick(1'b0, 1'b1, rd0, rd1);
        idle_tick(1'b1, 1'b1, rd0, rd1);
        for (int i = 0; i < 10; i++) idle_tick(1'b0, 1'b1, rd0, rd1);
        chk("drain_clr_pix_count", npix, NPIX);
        chk("drain_clr_done_pulses", done_cnt, 1);
        chk("drain_last_x", cap_x[NPIX-1], XM);
        chk("drain_last_y", cap_y[NPIX-1], YM);

        // Reset in the middle of a sweep, then normal service of req1
        idle_tick(1'b1, 1'b1, rd0, rd1);
        for (int i = 0; i < 3; i++) idle_tick(1'b0, 1'b1, rd0, rd1);
        chk("mid_clr_pix3_x", write_x, 8'd3);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd0, 9'd0, 1'b0, 8'd0, 8'd0, 9'd0, rd0, rd1);
        chk("rst_we", write_we, 1'b0);
        chk("rst_busy", clr_busy, 1'b0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 9'd0, 1'b1, 8'd9, 8'd9, 9'h1FF, rd0, rd1);
        chk("post_rst_rdy1", rd1, 1'b1);
        chk("post_rst_we", write_we, 1'b1);
        chk("post_rst_x", write_x, 8'd9);
        idle_tick(1'b0, 1'b1, rd0, rd1);

        // Random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom % 200) == 0, ($urandom % 25) == 0, ($urandom % 4) != 0,
                 1'($urandom), 8'($urandom), 8'($urandom), 9'($urandom),
                 1'($urandom), 8'($urandom), 8'($urandom), 9'($urandom), rd0, rd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
